// File: rtl/score_ctrl.sv
// rtl/score_ctrl.sv - game score/lives controller with BCD score, best-score tracking and post-game wait
module score_ctrl #(
    parameter int LIVES       = 3,
    parameter int WAIT_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       hit,
    input  logic       miss,
    output logic [7:0] score,
    output logic [1:0] state,
    output logic [7:0] best,
    output logic [1:0] lives
);

    localparam logic [1:0]  ST_INIT   = 2'd0;
    localparam logic [1:0]  ST_GAME   = 2'd1;
    localparam logic [1:0]  ST_WAIT   = 2'd2;
    localparam logic [1:0]  LIVES_L   = 2'(LIVES);
    localparam logic [25:0] WAIT_LAST = 26'(WAIT_CYCLES - 1);

    logic [1:0]  r_state;
    logic [7:0]  r_score;
    logic [7:0]  r_best;
    logic [1:0]  r_lives;
    logic [25:0] r_wait_cnt;
    logic        r_btn_prev;

    logic        w_start;
    logic [7:0]  w_score_inc;
    logic [7:0]  w_game_score;

    assign w_start = btn_start & ~r_btn_prev;

    // BCD increment saturating at 99
    always_comb begin
        w_score_inc = r_score;
        if (r_score == 8'h99) begin
            w_score_inc = 8'h99;
        end else if (r_score[3:0] >= 4'd9) begin
            w_score_inc = {r_score[7:4] + 4'd1, 4'd0};
        end else begin
            w_score_inc = {r_score[7:4], r_score[3:0] + 4'd1};
        end
    end

    assign w_game_score = hit ? w_score_inc : r_score;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_INIT;
            r_score    <= 8'h00;
            r_best     <= 8'h00;
            r_lives    <= LIVES_L;
            r_wait_cnt <= 26'd0;
            r_btn_prev <= 1'b1;
        end else begin
            r_btn_prev <= btn_start;
            case (r_state)
                ST_INIT: begin
                    r_lives <= LIVES_L;
                    if (w_start) begin
                        r_state <= ST_GAME;
                        r_score <= 8'h00;
                    end
                end
                ST_GAME: begin
                    r_score <= w_game_score;
                    if (miss) begin
                        if (r_lives > 2'd1) begin
                            r_lives <= r_lives - 2'd1;
                        end else begin
                            // Game over: best is judged on the score including this cycle's hit
                            r_lives    <= 2'd0;
                            r_state    <= ST_WAIT;
                            r_wait_cnt <= 26'd0;
                            if (w_game_score > r_best) begin
                                r_best <= w_game_score;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == WAIT_LAST) begin
                        r_state    <= ST_INIT;
                        r_lives    <= LIVES_L;
                        r_wait_cnt <= 26'd0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 26'd1;
                    end
                end
                default: begin
                    r_state    <= ST_INIT;
                    r_score    <= 8'h00;
                    r_lives    <= LIVES_L;
                    r_wait_cnt <= 26'd0;
                end
            endcase
        end
    end

    assign score = r_score;
    assign state = r_state;
    assign best  = r_best;
    assign lives = r_lives;

endmodule

// File: tb/tb_score_ctrl.sv
// tb/tb_score_ctrl.sv - scoreboard bench for score_ctrl (WAIT_CYCLES=4, LIVES=3)
module tb_score_ctrl;

    logic       clk;
    logic       rst_n;
    logic       btn_start;
    logic       hit;
    logic       miss;
    logic [7:0] score;
    logic [1:0] state;
    logic [7:0] best;
    logic [1:0] lives;

    int n_checks;
    int n_fail;

    logic [19:0] q_exp[$];
    logic [19:0] q_obs[$];

    score_ctrl #(.LIVES(3), .WAIT_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_start (btn_start),
        .hit       (hit),
        .miss      (miss),
        .score     (score),
        .state     (state),
        .best      (best),
        .lives     (lives)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int n);
        int t;
        int o;
        t = n / 10;
        o = n % 10;
        return {t[3:0], o[3:0]};
    endfunction

    // Packed expectation: {state, score, best, lives}
    function automatic logic [19:0] ex(input int st, input int sc, input int bs, input int lv);
        return {st[1:0], bcd(sc), bcd(bs), lv[1:0]};
    endfunction

    function automatic logic [19:0] obs_now();
        return {state, score, best, lives};
    endfunction

    task automatic cyc(input logic b, input logic h, input logic m, input logic [19:0] e);
        q_exp.push_back(e);
        btn_start = b;
        hit       = h;
        miss      = m;
        @(posedge clk);
        #1;
        q_obs.push_back(obs_now());
    endtask

    task automatic test_reset();
        logic [19:0] e;
        logic [19:0] o;
        rst_n = 1'b0; btn_start = 1'b1; hit = 1'b0; miss = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs_now() !== ex(0, 0, 0, 3)) begin
            n_fail++;
            $display("FAIL reset_values: got %h want %h", obs_now(), ex(0, 0, 0, 3));
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, ex(0, 0, 0, 3));
        while (q_exp.size() != 0) begin
            e = q_exp.pop_front(); o = q_obs.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL held_start_after_reset: got %h want %h", o, e); end
        end
    endtask

    task automatic test_basic();
        logic [19:0] e;
        logic [19:0] o;
        cyc(1'b0, 1'b0, 1'b0, ex(0, 0, 0, 3));
        cyc(1'b1, 1'b0, 1'b0, ex(1, 0, 0, 3));
        for (int n = 1; n <= 12; n++) cyc(1'b1, 1'b1, 1'b0, ex(1, n, 0, 3));
        cyc(1'b0, 1'b0, 1'b0, ex(1, 12, 0, 3));
        cyc(1'b1, 1'b0, 1'b0, ex(1, 12, 0, 3));
        while (q_exp.size() != 0) begin
            e = q_exp.pop_front(); o = q_obs.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL basic_start_hits: got %h want %h", o, e); end
        end
    endtask

    task automatic test_bcd_saturate();
        logic [19:0] e;
        logic [19:0] o;
        for (int n = 13; n <= 101; n++) cyc(1'b1, 1'b1, 1'b0, ex(1, (n > 99) ? 99 : n, 0, 3));
        while (q_exp.size() != 0) begin
            e = q_exp.pop_front(); o = q_obs.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL bcd_carry_saturate: got %h want %h", o, e); end
        end
    endtask

    task automatic test_reset_midgame();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs_now() !== ex(0, 0, 0, 3)) begin
            n_fail++;
            $display("FAIL async_reset_midgame: got %h want %h", obs_now(), ex(0, 0, 0, 3));
        end
        btn_start = 1'b0; hit = 1'b0; miss = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_gameover();
        logic [19:0] e;
        logic [19:0] o;
        cyc(1'b0, 1'b0, 1'b0, ex(0, 0, 0, 3));
        cyc(1'b1, 1'b0, 1'b0, ex(1, 0, 0, 3));
        for (int n = 1; n <= 5; n++) cyc(1'b1, 1'b1, 1'b0, ex(1, n, 0, 3));
        cyc(1'b1, 1'b0, 1'b1, ex(1, 5, 0, 2));
        cyc(1'b1, 1'b0, 1'b1, ex(1, 5, 0, 1));
        cyc(1'b1, 1'b1, 1'b1, ex(2, 6, 6, 0));
        while (q_exp.size() != 0) begin
            e = q_exp.pop_front(); o = q_obs.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL gameover_simultaneous: got %h want %h", o, e); end
        end
    endtask

    task automatic test_wait();
        logic [19:0] e;
        logic [19:0] o;
        cyc(1'b0, 1'b1, 1'b0, ex(2, 6, 6, 0));
        cyc(1'b1, 1'b1, 1'b1, ex(2, 6, 6, 0));
        cyc(1'b0, 1'b0, 1'b0, ex(2, 6, 6, 0));
        cyc(1'b0, 1'b0, 1'b0, ex(0, 6, 6, 3));
        cyc(1'b0, 1'b1, 1'b1, ex(0, 6, 6, 3));
        cyc(1'b1, 1'b0, 1'b0, ex(1, 0, 6, 3));
        while (q_exp.size() != 0) begin
            e = q_exp.pop_front(); o = q_obs.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL wait_timing: got %h want %h", o, e); end
        end
    endtask

    task automatic test_best_retention();
        logic [19:0] e;
        logic [19:0] o;
        for (int n = 1; n <= 3; n++) cyc(1'b1, 1'b1, 1'b0, ex(1, n, 6, 3));
        cyc(1'b1, 1'b0, 1'b1, ex(1, 3, 6, 2));
        cyc(1'b1, 1'b0, 1'b1, ex(1, 3, 6, 1));
        cyc(1'b1, 1'b0, 1'b1, ex(2, 3, 6, 0));
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, ex(2, 3, 6, 0));
        cyc(1'b1, 1'b0, 1'b0, ex(0, 3, 6, 3));
        cyc(1'b0, 1'b0, 1'b0, ex(0, 3, 6, 3));
        cyc(1'b1, 1'b0, 1'b0, ex(1, 0, 6, 3));
        for (int n = 1; n <= 7; n++) cyc(1'b1, 1'b1, 1'b0, ex(1, n, 6, 3));
        cyc(1'b1, 1'b0, 1'b1, ex(1, 7, 6, 2));
        cyc(1'b1, 1'b0, 1'b1, ex(1, 7, 6, 1));
        cyc(1'b1, 1'b0, 1'b1, ex(2, 7, 7, 0));
        while (q_exp.size() != 0) begin
            e = q_exp.pop_front(); o = q_obs.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL best_retention: got %h want %h", o, e); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_bcd_saturate();
        test_reset_midgame();
        test_gameover();
        test_wait();
        test_best_retention();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
